// File: rtl/axi4_lite_write_slave.sv
// AXI4-lite write slave: one-entry AW/W holding registers, a programmable delay,
// then a single strobed write on a synchronous memory port and a B response.
module axi4_lite_write_slave #(
   parameter int          ADDR_W     = 64,
   parameter int          DATA_W     = 64,
   parameter int          WR_LATENCY = 2,
   parameter logic [63:0] BASE       = 64'h8000_0000,
   parameter logic [63:0] SIZE       = 64'h0800_0000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADDR_W-1:0]   AW_ADDR,
   input  logic [2:0]          AW_PROT,
   input  logic                AW_VALID,
   output logic                AW_READY,
   input  logic [DATA_W-1:0]   W_DATA,
   input  logic [DATA_W/8-1:0] W_STRB,
   input  logic                W_VALID,
   output logic                W_READY,
   output logic [1:0]          B_RESP,
   output logic                B_VALID,
   input  logic                B_READY,
   output logic                mem_wen,
   output logic [ADDR_W-1:0]   mem_waddr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask
);
   localparam int STRB_W = DATA_W / 8;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] DELAY = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   localparam logic [3:0] CNT_INIT = (WR_LATENCY == 0) ? 4'd0 : 4'(WR_LATENCY - 1);

   // Region bounds carried one bit wider so BASE+SIZE cannot wrap.
   localparam logic [ADDR_W:0] LO = (ADDR_W + 1)'(BASE);
   localparam logic [ADDR_W:0] HI = LO + (ADDR_W + 1)'(SIZE);

   logic [1:0]        state;
   logic [3:0]        cnt;
   logic              aw_full;
   logic              w_full;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic [STRB_W-1:0] strb_q;
   logic              aw_hs;
   logic              w_hs;
   logic              addr_ok;
   logic              wr_cyc;
   logic              unused_prot;

   assign AW_READY = !rst && (state == IDLE) && !aw_full;
   assign W_READY  = !rst && (state == IDLE) && !w_full;
   assign aw_hs    = AW_VALID && AW_READY;
   assign w_hs     = W_VALID && W_READY;

   assign addr_ok = ({1'b0, addr_q} >= LO) && ({1'b0, addr_q} < HI) &&
                    (addr_q[2:0] == 3'b000);

   always_ff @(posedge clk) begin
      if (aw_hs) addr_q <= AW_ADDR;
      if (w_hs) begin
         data_q <= W_DATA;
         strb_q <= W_STRB;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         aw_full <= 1'b0;
         w_full  <= 1'b0;
         B_VALID <= 1'b0;
         B_RESP  <= 2'b00;
      end else begin
         if (aw_hs) aw_full <= 1'b1;
         if (w_hs)  w_full  <= 1'b1;
         case (state)
            IDLE: begin
               if (aw_full && w_full) begin
                  cnt   <= CNT_INIT;
                  state <= (WR_LATENCY == 0) ? WRITE : DELAY;
               end
            end
            DELAY: begin
               if (cnt == 4'd0) state <= WRITE;
               else             cnt   <= cnt - 4'd1;
            end
            WRITE: begin
               state   <= RESP;
               B_VALID <= 1'b1;
               B_RESP  <= addr_ok ? 2'b00 : 2'b10;
            end
            RESP: begin
               if (B_READY) begin
                  B_VALID <= 1'b0;
                  aw_full <= 1'b0;
                  w_full  <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Memory port is live only in the WRITE cycle; rst in that cycle kills the strobe.
   assign wr_cyc    = !rst && (state == WRITE);
   assign mem_wen   = wr_cyc && addr_ok;
   assign mem_waddr = wr_cyc ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
   assign mem_wdata = wr_cyc ? data_q : '0;
   assign mem_wmask = wr_cyc ? strb_q : '0;

   assign unused_prot = ^AW_PROT;

endmodule

// File: tb/tb_axi4_lite_write_slave.sv
// Bench for axi4_lite_write_slave: table vectors, random transactions against a
// transaction-level model, and hand sequences for reset and zero-latency builds.
module tb_axi4_lite_write_slave;
   localparam int LAT = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [63:0] aw_addr, w_data, mem_waddr, mem_wdata;
   logic [2:0]  aw_prot;
   logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready, mem_wen;
   logic [7:0]  w_strb, mem_wmask;
   logic [1:0]  b_resp;

   logic [63:0] z_aw_addr, z_w_data, z_mem_waddr, z_mem_wdata;
   logic [2:0]  z_aw_prot;
   logic        z_aw_valid, z_aw_ready, z_w_valid, z_w_ready, z_b_valid, z_b_ready, z_mem_wen;
   logic [7:0]  z_w_strb, z_mem_wmask;
   logic [1:0]  z_b_resp;

   int total = 0;
   int bad   = 0;

   axi4_lite_write_slave dut (
      .clk(clk), .rst(rst),
      .AW_ADDR(aw_addr), .AW_PROT(aw_prot), .AW_VALID(aw_valid), .AW_READY(aw_ready),
      .W_DATA(w_data), .W_STRB(w_strb), .W_VALID(w_valid), .W_READY(w_ready),
      .B_RESP(b_resp), .B_VALID(b_valid), .B_READY(b_ready),
      .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask)
   );

   axi4_lite_write_slave #(.WR_LATENCY(0)) dut0 (
      .clk(clk), .rst(rst),
      .AW_ADDR(z_aw_addr), .AW_PROT(z_aw_prot), .AW_VALID(z_aw_valid), .AW_READY(z_aw_ready),
      .W_DATA(z_w_data), .W_STRB(z_w_strb), .W_VALID(z_w_valid), .W_READY(z_w_ready),
      .B_RESP(z_b_resp), .B_VALID(z_b_valid), .B_READY(z_b_ready),
      .mem_wen(z_mem_wen), .mem_waddr(z_mem_waddr), .mem_wdata(z_mem_wdata), .mem_wmask(z_mem_wmask)
   );

   typedef struct {
      logic [63:0] addr;
      logic [63:0] data;
      logic [7:0]  strb;
      int          aw_dly;
      int          w_dly;
      int          b_dly;
      logic [1:0]  resp;
      logic        wen;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Accepted region is [0x8000_0000, 0x8800_0000) with 8-byte alignment.
   function automatic logic [1:0] model_resp(input logic [63:0] a);
      if (a < 64'h8000_0000 || a >= 64'h8800_0000 || (a % 8) != 0) return 2'b10;
      return 2'b00;
   endfunction

   // One full transaction on dut; starts and ends just after a rising edge.
   task automatic run_txn(input string tag, input logic [63:0] a, input logic [63:0] d,
                          input logic [7:0] s, input int aw_dly, input int w_dly,
                          input int b_dly, input logic [1:0] er, input logic ew);
      int aw_c = -1, w_c = -1, wen_c = -1, bv_c = -1, bh_c = -1;
      int wen_n = 0, stall = 0, unstable = 0, cyc = 0, hs;
      logic [63:0] wa = '0, wd = '0;
      logic [7:0]  wm = '0;
      logic [1:0]  r = '0;
      hs = (aw_dly > w_dly) ? aw_dly : w_dly;
      while (bh_c < 0 && cyc < 100) begin
         aw_valid = (aw_c < 0) && (cyc >= aw_dly);
         aw_addr  = a;
         aw_prot  = 3'($urandom);
         w_valid  = (w_c < 0) && (cyc >= w_dly);
         w_data   = d;
         w_strb   = s;
         b_ready  = (b_dly == 0) || (b_valid && bv_c >= 0 && (cyc - bv_c) >= b_dly);
         @(negedge clk);
         if (aw_c >= 0 && aw_ready) stall++;
         if (w_c >= 0 && w_ready) stall++;
         if (aw_valid && aw_ready) aw_c = cyc;
         if (w_valid && w_ready) w_c = cyc;
         if (mem_wen) begin
            wen_n++;
            wen_c = cyc;
            wa = mem_waddr;
            wd = mem_wdata;
            wm = mem_wmask;
         end
         if (bv_c >= 0 && (!b_valid || b_resp != r)) unstable++;
         if (b_valid && bv_c < 0) begin
            bv_c = cyc;
            r = b_resp;
         end
         if (b_valid && b_ready) bh_c = cyc;
         @(posedge clk); #1;
         cyc++;
      end
      aw_valid = 1'b0;
      w_valid  = 1'b0;
      b_ready  = 1'b0;
      chk({tag, "_done"}, 64'(bh_c >= 0), 64'd1);
      chk({tag, "_aw_hs"}, 64'(aw_c), 64'(aw_dly));
      chk({tag, "_w_hs"}, 64'(w_c), 64'(w_dly));
      chk({tag, "_resp"}, 64'(r), 64'(er));
      chk({tag, "_wen_n"}, 64'(wen_n), 64'(ew));
      if (ew) begin
         chk({tag, "_wen_cyc"}, 64'(wen_c), 64'(hs + 2 + LAT));
         chk({tag, "_waddr"}, wa, {a[63:3], 3'b000});
         chk({tag, "_wdata"}, wd, d);
         chk({tag, "_wmask"}, 64'(wm), 64'(s));
      end
      chk({tag, "_bv_cyc"}, 64'(bv_c), 64'(hs + 3 + LAT));
      chk({tag, "_bh_cyc"}, 64'(bh_c), 64'(hs + 3 + LAT + b_dly));
      chk({tag, "_stall"}, 64'(stall), 64'd0);
      chk({tag, "_b_stable"}, 64'(unstable), 64'd0);
      @(negedge clk);
      chk({tag, "_ready_after"}, 64'({aw_ready, w_ready}), 64'd3);
      @(posedge clk); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      aw_addr = '0; aw_prot = '0; aw_valid = 1'b0; w_data = '0; w_strb = '0;
      w_valid = 1'b0; b_ready = 1'b0;
      z_aw_addr = '0; z_aw_prot = '0; z_aw_valid = 1'b0; z_w_data = '0; z_w_strb = '0;
      z_w_valid = 1'b0; z_b_ready = 1'b0;

      vecs[0]  = '{64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 0, 0, 0, 2'b00, 1'b1};
      vecs[1]  = '{64'h8000_0008, 64'hCAFE_F00D_DEAD_BEEF, 8'h0F, 3, 0, 0, 2'b00, 1'b1};
      vecs[2]  = '{64'h8000_0100, 64'h0123_4567_89AB_CDEF, 8'hAA, 0, 2, 1, 2'b00, 1'b1};
      vecs[3]  = '{64'h7FFF_FFF8, 64'h5555_AAAA_5555_AAAA, 8'hFF, 0, 0, 0, 2'b10, 1'b0};
      vecs[4]  = '{64'h8000_0004, 64'h1111_2222_3333_4444, 8'hFF, 0, 0, 0, 2'b10, 1'b0};
      vecs[5]  = '{64'h8000_0020, 64'h9999_8888_7777_6666, 8'h3C, 0, 0, 6, 2'b00, 1'b1};
      vecs[6]  = '{64'h8000_0030, 64'hFFFF_0000_FFFF_0000, 8'h00, 1, 1, 0, 2'b00, 1'b1};
      vecs[7]  = '{64'h87FF_FFF8, 64'h0A0B_0C0D_0E0F_1011, 8'hF0, 0, 0, 0, 2'b00, 1'b1};
      vecs[8]  = '{64'h8800_0000, 64'h1234_1234_1234_1234, 8'hFF, 0, 0, 0, 2'b10, 1'b0};
      vecs[9]  = '{64'h8000_0000, 64'h8765_4321_8765_4321, 8'h81, 2, 2, 2, 2'b00, 1'b1};
      vecs[10] = '{64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 8'hFF, 0, 1, 0, 2'b10, 1'b0};
      vecs[11] = '{64'h8000_0001, 64'h7, 8'h01, 0, 0, 3, 2'b10, 1'b0};

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 64'({aw_ready, w_ready}), 64'd0);
      chk("rst_b", 64'({b_valid, b_resp}), 64'd0);
      chk("rst_mem", 64'(mem_wen) | mem_waddr | mem_wdata | 64'(mem_wmask), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", 64'({aw_ready, w_ready}), 64'd3);
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++)
         run_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].strb,
                 vecs[i].aw_dly, vecs[i].w_dly, vecs[i].b_dly, vecs[i].resp, vecs[i].wen);

      for (int i = 0; i < 30; i++) begin
         logic [63:0] a;
         int k;
         k = int'($urandom_range(0, 3));
         case (k)
            0:       a = 64'h8000_0000 + 64'($urandom_range(0, 32'h00FF_FFFF)) * 64'd8;
            1:       a = 64'h8000_0000 + 64'($urandom_range(0, 32'h07FF_FFFF));
            2:       a = {$urandom, $urandom};
            default: a = 64'h8800_0000 - 64'($urandom_range(0, 16));
         endcase
         run_txn($sformatf("rnd%0d", i), a, {$urandom, $urandom}, 8'($urandom),
                 int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                 int'($urandom_range(0, 3)), model_resp(a), model_resp(a) == 2'b00);
      end

      // Reset while the write sits in DELAY: nothing may reach memory or B.
      begin
         int wen_n = 0, bv_n = 0;
         for (int cyc = 0; cyc < 10; cyc++) begin
            rst      = (cyc == 2);
            aw_valid = (cyc == 0);
            w_valid  = (cyc == 0);
            aw_addr  = 64'h8000_0040;
            w_data   = 64'hABCD_ABCD_ABCD_ABCD;
            w_strb   = 8'hFF;
            b_ready  = 1'b1;
            @(negedge clk);
            if (cyc == 0) chk("rstd_hs", 64'({aw_ready, w_ready}), 64'd3);
            if (cyc == 2) chk("rstd_ready_low", 64'({aw_ready, w_ready}), 64'd0);
            if (cyc == 3) chk("rstd_ready_back", 64'({aw_ready, w_ready}), 64'd3);
            if (mem_wen) wen_n++;
            if (b_valid) bv_n++;
            @(posedge clk); #1;
         end
         rst = 1'b0; aw_valid = 1'b0; w_valid = 1'b0; b_ready = 1'b0;
         chk("rstd_no_wen", 64'(wen_n), 64'd0);
         chk("rstd_no_b", 64'(bv_n), 64'd0);
      end
      run_txn("after_rstd", 64'h8000_0048, 64'h0F0F_0F0F_0F0F_0F0F, 8'h33, 0, 0, 0, 2'b00, 1'b1);

      // Reset while B is waiting: B_VALID drops the cycle after the rst edge.
      begin
         int seen = 0;
         for (int cyc = 0; cyc < 20 && seen == 0; cyc++) begin
            aw_valid = (cyc == 0);
            w_valid  = (cyc == 0);
            aw_addr  = 64'h8000_0050;
            b_ready  = 1'b0;
            @(negedge clk);
            if (b_valid) seen = 1;
            @(posedge clk); #1;
         end
         chk("rstr_bv_seen", 64'(seen), 64'd1);
         aw_valid = 1'b0; w_valid = 1'b0;
         rst = 1'b1;
         @(posedge clk); #1;
         rst = 1'b0;
         @(negedge clk);
         chk("rstr_bv_drop", 64'({b_valid, b_resp}), 64'd0);
         chk("rstr_ready", 64'({aw_ready, w_ready}), 64'd3);
         @(posedge clk); #1;
      end

      // Zero-latency build: WRITE two cycles after the handshake, B one after that.
      begin
         int wen_c = -1, wen_n = 0, bv_c = -1;
         for (int cyc = 0; cyc < 8; cyc++) begin
            z_aw_valid = (cyc == 0);
            z_w_valid  = (cyc == 0);
            z_aw_addr  = 64'h8000_0018;
            z_w_data   = 64'h0102_0304_0506_0708;
            z_w_strb   = 8'h5A;
            z_b_ready  = 1'b1;
            @(negedge clk);
            if (cyc == 0) chk("lat0_hs", 64'({z_aw_ready, z_w_ready}), 64'd3);
            if (z_mem_wen) begin
               wen_n++;
               wen_c = cyc;
               chk("lat0_waddr", z_mem_waddr, 64'h8000_0018);
               chk("lat0_wmask", 64'(z_mem_wmask), 64'h5A);
            end
            if (z_b_valid && bv_c < 0) begin
               bv_c = cyc;
               chk("lat0_resp", 64'(z_b_resp), 64'd0);
            end
            @(posedge clk); #1;
         end
         z_aw_valid = 1'b0; z_w_valid = 1'b0;
         chk("lat0_wen_n", 64'(wen_n), 64'd1);
         chk("lat0_wen_cyc", 64'(wen_c), 64'd2);
         chk("lat0_bv_cyc", 64'(bv_c), 64'd3);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
